// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data_memory block: default geometry, the word
// type, the reset word, and the single address-decode function that yields
// both the word index and the in-range flag.
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_DEPTH  = 64;

  typedef logic [DMEM_DATA_W-1:0] word_t;

  localparam word_t WORD_RST = '0;

  typedef struct packed {
    logic        in_range;
    logic [31:0] idx;
  } dmem_dec_t;

  // Byte address -> word index (low two bits dropped, masked to idx_w bits).
  // With bounds_en clear every address is in range and the index wraps;
  // with it set, any nonzero bit above the index field marks it out of range.
  function automatic dmem_dec_t dmem_decode(input logic [63:0] addr,
                                            input int unsigned idx_w,
                                            input logic bounds_en);
    dmem_dec_t   dec;
    logic [63:0] word_addr;
    logic [63:0] mask;
    word_addr    = addr >> 2;
    mask         = (64'd1 << idx_w) - 64'd1;
    dec.idx      = 32'(word_addr & mask);
    dec.in_range = !bounds_en || ((word_addr & ~mask) == 64'd0);
    return dec;
  endfunction

endpackage

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-addressable data RAM for the core's load/store path. One
// combinational read port and one synchronous write port share a single
// byte address. A synchronous active-low reset clears the whole array and
// wins over a simultaneous write.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-low reset
//   MemWrite  - write enable, sampled at the rising edge
//   A         - byte address (A[1:0] ignored)
//   WD        - write data
//   RD        - combinational read data for the word at A
//
// Build option DMEM_BOUNDS_CHECK_EN: when defined, addresses with any bit
// set above the index field are out of range (writes ignored, reads 0).
// When undefined, upper address bits are ignored and the index wraps.
// ---------------------------------------------------------------------------
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  dmem_dec_t         dec;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    dec = dmem_decode(64'(A), IDX_W, BOUNDS_EN);
    idx = dec.idx[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(WORD_RST);
      end
    end else if (MemWrite && dec.in_range) begin
      mem_q[idx] <= WD;
    end
  end

  always_comb begin
    RD = '0;
    if (dec.in_range) begin
      RD = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          MemWrite;
  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic [DW-1:0] RD;

  int tests = 0;
  int fails = 0;

  // Reference model: plain array of words indexed by byte address / 4.
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .A(A), .WD(WD), .RD(RD)
  );

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    int unsigned w = a / 4;
    if (BOUNDS && w >= DEPTH) return '0;
    return ref_mem[w % DEPTH];
  endfunction

  // Apply the model's view of the coming edge, then advance past it.
  task automatic tick();
    int unsigned w = A / 4;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (MemWrite && !(BOUNDS && w >= DEPTH)) begin
      ref_mem[w % DEPTH] = WD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    A = a; WD = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; MemWrite = 1'b0; A = '0; WD = '0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i += 9) begin
      A = AW'(i * 4); #1;
      tests++;
      if (RD !== '0) begin
        fails++;
        $display("FAIL reset_clear A=%0d RD=%h expected=%h", A, RD, 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    A = 32'd8; WD = 32'hAAAA_BBBB; MemWrite = 1'b0;
    tick();
    tests++;
    if (RD !== 32'h0) begin
      fails++; $display("FAIL basic_no_we RD=%h expected=%h", RD, 32'h0);
    end
    MemWrite = 1'b1;
    tick();
    tests++;
    if (RD !== 32'hAAAA_BBBB) begin
      fails++; $display("FAIL basic_write RD=%h expected=%h", RD, 32'hAAAA_BBBB);
    end
    MemWrite = 1'b0;
    tick();
    tests++;
    if (RD !== 32'hAAAA_BBBB) begin
      fails++; $display("FAIL basic_hold RD=%h expected=%h", RD, 32'hAAAA_BBBB);
    end
  endtask

  task automatic test_isolation();
    write_word(32'd12, 32'hCCCC_DDDD);
    tests++;
    if (RD !== 32'hCCCC_DDDD) begin
      fails++; $display("FAIL iso_a12 RD=%h expected=%h", RD, 32'hCCCC_DDDD);
    end
    A = 32'd8; #1;
    tests++;
    if (RD !== 32'hAAAA_BBBB) begin
      fails++; $display("FAIL iso_a8 RD=%h expected=%h", RD, 32'hAAAA_BBBB);
    end
  endtask

  task automatic test_reset_priority();
    logic [AW-1:0] addrs [3];
    addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd252;
    write_word(32'd0,   32'h0BAD_F00D);
    write_word(32'd4,   32'h7777_8888);
    write_word(32'd252, 32'hFFFF_0001);
    A = 32'd252; #1;
    tests++;
    if (RD !== 32'hFFFF_0001) begin
      fails++; $display("FAIL rstp_prefill RD=%h expected=%h", RD, 32'hFFFF_0001);
    end
    rst = 1'b0; MemWrite = 1'b1; A = 32'd4; WD = 32'h1234_5678;
    tick();
    rst = 1'b1; MemWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = addrs[i]; #1;
      tests++;
      if (RD !== 32'h0) begin
        fails++; $display("FAIL rstp_clear A=%0d RD=%h expected=%h", A, RD, 32'h0);
      end
    end
  endtask

  task automatic test_unaligned();
    write_word(32'd16, 32'hDEAD_BEEF);
    for (int i = 17; i <= 19; i++) begin
      A = AW'(i); #1;
      tests++;
      if (RD !== 32'hDEAD_BEEF) begin
        fails++; $display("FAIL unaligned A=%0d RD=%h expected=%h", A, RD, 32'hDEAD_BEEF);
      end
    end
  endtask

  task automatic test_rdw();
    write_word(32'd20, 32'h1111_1111);
    A = 32'd20; WD = 32'h2222_2222; MemWrite = 1'b1; #1;
    tests++;
    if (RD !== 32'h1111_1111) begin
      fails++; $display("FAIL rdw_before RD=%h expected=%h", RD, 32'h1111_1111);
    end
    tick();
    MemWrite = 1'b0;
    tests++;
    if (RD !== 32'h2222_2222) begin
      fails++; $display("FAIL rdw_after RD=%h expected=%h", RD, 32'h2222_2222);
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp256;
    write_word(32'd0, 32'h0000_00A5);
    write_word(32'd256, 32'h5555_5555);
    exp0   = BOUNDS ? 32'h0000_00A5 : 32'h5555_5555;
    exp256 = BOUNDS ? 32'h0        : 32'h5555_5555;
    A = 32'd0; #1;
    tests++;
    if (RD !== exp0) begin
      fails++; $display("FAIL oor_a0 RD=%h expected=%h", RD, exp0);
    end
    A = 32'd256; #1;
    tests++;
    if (RD !== exp256) begin
      fails++; $display("FAIL oor_a256 RD=%h expected=%h", RD, exp256);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp;
    for (int n = 0; n < 300; n++) begin
      A        = AW'($urandom_range(0, 511));
      WD       = $urandom;
      MemWrite = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 39) != 0);
      #1;
      exp = model_rd(A);
      tests++;
      if (RD !== exp) begin
        fails++; $display("FAIL rand_pre n=%0d A=%0d RD=%h expected=%h", n, A, RD, exp);
      end
      tick();
      exp = model_rd(A);
      tests++;
      if (RD !== exp) begin
        fails++; $display("FAIL rand_post n=%0d A=%0d RD=%h expected=%h", n, A, RD, exp);
      end
      // Read back a different random address to catch stray writes.
      A = AW'($urandom_range(0, 511)); #1;
      exp = model_rd(A);
      tests++;
      if (RD !== exp) begin
        fails++; $display("FAIL rand_other n=%0d A=%0d RD=%h expected=%h", n, A, RD, exp);
      end
    end
    rst = 1'b1; MemWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_basic();
    test_isolation();
    test_reset_priority();
    test_unaligned();
    test_rdw();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
